param_control_unit: RTL

PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

---
 rtl/param_control_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/param_control_unit.sv
// Sequencer for an add/sub, Booth-multiply and non-restoring-divide datapath.
// Optional feature: define DIV_ZERO_DETECT_EN to abort divides by zero after LOAD.
module param_control_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op_codes,
  input  logic        q_zero,
  input  logic        q_minus_one,
  input  logic        a_msb,
  input  logic        divisor_zero,
  output logic [10:0] c,
  output logic        busy,
  output logic        finish,
  output logic        div_zero_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_CORR,
    S_OUT,
    S_DONE
  } state_e;

  localparam logic [1:0]       OP_MUL    = 2'b10;
  localparam logic [1:0]       OP_DIV    = 2'b11;
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic             err_q, err_d;

  logic iter_done;
  assign iter_done = (iter_q == ITER_LAST);

`ifndef DIV_ZERO_DETECT_EN
  logic unused_divisor_zero;
  assign unused_divisor_zero = divisor_zero;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    iter_d  = iter_q;
    op_d    = op_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          step_d  = 2'd0;
          iter_d  = '0;
          op_d    = op_codes;
        end
      end
      S_LOAD: begin
        if (step_q == 2'd0) begin
          step_d = 2'd1;
        end else begin
          state_d = S_EXEC;
          step_d  = 2'd0;
          iter_d  = '0;
`ifdef DIV_ZERO_DETECT_EN
          if (op_q == OP_DIV && divisor_zero) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      S_EXEC: begin
        if (!op_q[1]) begin
          state_d = S_OUT;
          step_d  = 2'd0;
        end else if (op_q == OP_MUL) begin
          if (step_q == 2'd0) begin
            step_d = 2'd1;
          end else begin
            step_d = 2'd0;
            // Counter returns to 0 on the last iteration instead of wrapping.
            iter_d = iter_done ? '0 : iter_q + ITER_ONE;
            if (iter_done) state_d = S_OUT;
          end
        end else begin
          if (step_q != 2'd2) begin
            step_d = step_q + 2'd1;
          end else begin
            step_d = 2'd0;
            iter_d = iter_done ? '0 : iter_q + ITER_ONE;
            if (iter_done) state_d = a_msb ? S_CORR : S_OUT;
          end
        end
      end
      S_CORR: begin
        state_d = S_OUT;
        step_d  = 2'd0;
      end
      S_OUT: begin
        if (!op_q[1] || step_q == 2'd1) begin
          state_d = S_DONE;
          step_d  = 2'd0;
        end else begin
          step_d = 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 2'd0;
        iter_d  = '0;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    finish_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      step_q   <= 2'd0;
      iter_q   <= '0;
      op_q     <= 2'b00;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      iter_q   <= iter_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      err_q    <= err_d;
    end
  end

  // Control word: registered state/step/op plus live datapath status bits.
  always_comb begin
    c = '0;
    unique case (state_q)
      S_LOAD: begin
        if (step_q == 2'd0) begin
          c[0] = 1'b1;
          c[8] = op_q[1];
        end else begin
          c[1] = 1'b1;
        end
      end
      S_EXEC: begin
        if (!op_q[1]) begin
          c[2] = 1'b1;
          c[3] = op_q[0];
        end else if (op_q == OP_MUL) begin
          if (step_q == 2'd0) begin
            c[2] = q_zero ^ q_minus_one;
            c[3] = q_zero & ~q_minus_one;
          end else begin
            c[5] = 1'b1;
          end
        end else begin
          unique case (step_q)
            2'd0: c[4] = 1'b1;
            2'd1: begin
              c[2] = 1'b1;
              c[3] = ~a_msb;
            end
            default: c[9] = 1'b1;
          endcase
        end
      end
      S_CORR: begin
        c[2] = 1'b1;
        c[6] = 1'b1;
      end
      S_OUT: begin
        if (op_q[1] && step_q == 2'd0) c[7] = 1'b1;
        else                           c[10] = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign busy         = busy_q;
  assign finish       = finish_q;
  assign div_zero_err = err_q;

endmodule
